// File: rtl/fp16_mac_out_buffer_if.sv
// fp16_mac_out_buffer_if: result intake and drain port bundle.
// The buffer side uses slave; the feeder/consumer side uses master.
interface fp16_mac_out_buffer_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic [1:0]  in_opcode;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_opcode,
        input  out_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output in_opcode,
        output out_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/fp16_mac_out_buffer.sv
// fp16_mac_out_buffer: FP16 post-op and result FIFO behind the MAC.
// Raises upstream_hold early so in-flight MAC results always fit.
module fp16_mac_out_buffer #(
    parameter int DEPTH   = 8,
    parameter int RESERVE = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    fp16_mac_out_buffer_if.slave     bus,
    output logic                     upstream_hold,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_AT = CW'(DEPTH);
    localparam logic [CW-1:0] HOLD_AT = CW'(DEPTH - RESERVE);

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          hold_q;
    logic          ovf_q;

    logic [15:0]   post_w;
    logic          is_nan;
    logic          full;
    logic          pop;
    logic          accept;
    logic          drop;

    assign is_nan = (bus.in_data[14:10] == 5'h1F)
                 && (bus.in_data[9:0] != 10'd0);

    // Opcode-selected post-op; ReLU lets NaN through untouched.
    always_comb begin
        post_w = bus.in_data;
        unique case (bus.in_opcode)
            2'd0: post_w = bus.in_data;
            2'd1: begin
                if (bus.in_data[15] && !is_nan)
                    post_w = 16'h0000;
            end
            2'd2: post_w = {~bus.in_data[15], bus.in_data[14:0]};
            2'd3: post_w = {1'b0, bus.in_data[14:0]};
        endcase
    end

    assign full   = (count_q == FULL_AT);
    assign pop    = (count_q != '0) && bus.out_ready;
    assign accept = bus.in_valid && (!full || pop);
    assign drop   = bus.in_valid && full && !pop;

    // Occupancy after this edge; hold is derived from it.
    always_comb begin
        count_d = count_q + CW'(accept) - CW'(pop);
    end

    // Pointers, occupancy, hold and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (accept)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            hold_q  <= (count_d >= HOLD_AT);
            if (drop)
                ovf_q <= 1'b1;
        end
    end

    // Storage is not cleared on reset; only accepted words are written.
    always_ff @(posedge clk) begin
        if (!rst && accept)
            mem_q[wr_ptr_q] <= post_w;
    end

    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign upstream_hold = hold_q;
    assign count         = count_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_fp16_mac_out_buffer.sv
// tb_fp16_mac_out_buffer: directed checks of post-op, FIFO order,
// hold threshold, overflow, wrap-around and reset (DEPTH=8, RESERVE=4).
module tb_fp16_mac_out_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       upstream_hold;
    logic [3:0] count;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    fp16_mac_out_buffer_if bus();

    fp16_mac_out_buffer #(.DEPTH(8), .RESERVE(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave),
        .upstream_hold (upstream_hold),
        .count         (count),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic state(input string tag, input logic [3:0] c,
                         input logic v, input logic h, input logic o);
        chk({tag, ".count"}, 16'(count), 16'(c));
        chk({tag, ".valid"}, 16'(bus.out_valid), 16'(v));
        chk({tag, ".hold"}, 16'(upstream_hold), 16'(h));
        chk({tag, ".ovf"}, 16'(overflow), 16'(o));
    endtask

    task automatic push(input logic [15:0] d, input logic [1:0] op);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_opcode = op;
        tick();
        bus.in_valid  = 1'b0;
    endtask

    task automatic postop(input string tag, input logic [15:0] d,
                          input logic [1:0] op, input logic [15:0] exp);
        push(d, op);
        chk({tag, ".valid"}, 16'(bus.out_valid), 16'h1);
        chk({tag, ".data"}, bus.out_data, exp);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, ".cnt0"}, 16'(count), 16'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0;
        bus.in_opcode = 2'd0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        state("reset", 4'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Pop on empty is ignored.
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        state("empty_pop", 4'd0, 1'b0, 1'b0, 1'b0);

        // Single push, pass-through, then pop.
        push(16'h3C00, 2'd0);
        state("single", 4'd1, 1'b1, 1'b0, 1'b0);
        chk("single.data", bus.out_data, 16'h3C00);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        state("single_pop", 4'd0, 1'b0, 1'b0, 1'b0);

        // Post-op coverage.
        postop("relu_neg1", 16'hBC00, 2'd1, 16'h0000);
        postop("relu_negz", 16'h8000, 2'd1, 16'h0000);
        postop("relu_nan", 16'hFE01, 2'd1, 16'hFE01);
        postop("relu_pos", 16'h4200, 2'd1, 16'h4200);
        postop("relu_ninf", 16'hFC00, 2'd1, 16'h0000);
        postop("neg", 16'h4200, 2'd2, 16'hC200);
        postop("neg_nan", 16'h7E01, 2'd2, 16'hFE01);
        postop("abs", 16'hFC00, 2'd3, 16'h7C00);

        // Hold threshold: rises after 4th push, falls after one pop.
        for (int i = 0; i < 3; i++)
            push(16'h0010 + 16'(i), 2'd0);
        state("hold3", 4'd3, 1'b1, 1'b0, 1'b0);
        push(16'h0013, 2'd0);
        state("hold4", 4'd4, 1'b1, 1'b1, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        state("hold_pop", 4'd3, 1'b1, 1'b0, 1'b0);
        chk("hold_pop.data", bus.out_data, 16'h0011);
        bus.out_ready = 1'b1;
        tick();
        tick();
        tick();
        bus.out_ready = 1'b0;
        state("hold_drain", 4'd0, 1'b0, 1'b0, 1'b0);

        // Overflow: 9 pushes into 8 slots, 0009 lost.
        for (int i = 1; i <= 8; i++)
            push(16'(i), 2'd0);
        state("full8", 4'd8, 1'b1, 1'b1, 1'b0);
        push(16'h0009, 2'd0);
        state("ovf", 4'd8, 1'b1, 1'b1, 1'b1);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("ovf_drain%0d", i), bus.out_data, 16'(i));
            tick();
        end
        bus.out_ready = 1'b0;
        state("ovf_empty", 4'd0, 1'b0, 1'b0, 1'b1);

        // Reset clears sticky overflow and queued words; push ignored.
        for (int i = 0; i < 5; i++)
            push(16'h0020 + 16'(i), 2'd0);
        state("pre_rst", 4'd5, 1'b1, 1'b1, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0EEE;
        do_reset();
        bus.in_valid = 1'b0;
        state("rst_mid", 4'd0, 1'b0, 1'b0, 1'b0);

        // Full with simultaneous push and pop is accepted.
        for (int i = 0; i < 8; i++)
            push(16'h0011 + 16'(i), 2'd0);
        state("full_b", 4'd8, 1'b1, 1'b1, 1'b0);
        bus.out_ready = 1'b1;
        push(16'h00AA, 2'd0);
        state("full_pp", 4'd8, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("pp_drain%0d", i), bus.out_data,
                16'h0011 + 16'(i));
            tick();
        end
        chk("pp_last", bus.out_data, 16'h00AA);
        tick();
        bus.out_ready = 1'b0;
        state("pp_empty", 4'd0, 1'b0, 1'b0, 1'b0);

        // Streaming through the wrap point at one word per cycle.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h0100 + 16'(i);
            bus.in_opcode = 2'd0;
            tick();
            chk($sformatf("wrap%0d.data", i), bus.out_data,
                16'h0100 + 16'(i));
            chk($sformatf("wrap%0d.cnt", i), 16'(count), 16'h1);
        end
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        state("wrap_end", 4'd0, 1'b0, 1'b0, 1'b0);

        // Reset with 3 queued.
        for (int i = 0; i < 3; i++)
            push(16'h0200 + 16'(i), 2'd0);
        state("q3", 4'd3, 1'b1, 1'b0, 1'b0);
        chk("q3.data", bus.out_data, 16'h0200);
        do_reset();
        state("rst3", 4'd0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/fp16_mac_out_buffer.md
# fp16_mac_out_buffer

Downstream stage for `FP16_MAC_pipeline`. It captures each result the MAC presents on `output_up`/`data_o`/`opcode_o` and applies an opcode-selected FP16 post-operation. Results are queued in a FIFO and drained through a valid/ready port. Because the MAC has no stall input, the block raises `upstream_hold` early enough that the feeder can drop `input_valid` before the results still in flight overrun the FIFO.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, minimum 4.
- `RESERVE`, 4: slots kept free for results already inside the MAC pipeline; must satisfy 1 ≤ RESERVE < DEPTH.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: result strobe; connects to MAC `output_up`.
- `in_data`, in, 16: FP16 result; connects to MAC `data_o`.
- `in_opcode`, in, 2: post-op select; connects to MAC `opcode_o`.
- `upstream_hold`, out, 1: feeder must not raise MAC `input_valid` while this is high.
- `out_valid`, out, 1: FIFO head is valid.
- `out_data`, out, 16: post-processed FP16 word at the FIFO head.
- `out_ready`, in, 1: consumer accepts the head this cycle.
- `count`, out, $clog2(DEPTH)+1: current occupancy.
- `overflow`, out, 1: sticky flag; set when a result is dropped.

## Operation
- Post-op is combinational on `in_data` and is selected by `in_opcode`:
  - 0: pass through.
  - 1: ReLU. Any word with sign=1 becomes 16'h0000, including -0 and -inf. Exception: NaN (exp=5'h1F, mant≠0) passes unchanged.
  - 2: negate. Flip bit 15. This applies to all encodings, including NaN.
  - 3: abs. Clear bit 15.
- Push: `in_valid`=1 writes the post-op word at `wr_ptr`, then `wr_ptr`++ (wraps modulo DEPTH).
- Pop: `out_valid && out_ready` advances `rd_ptr` (wraps modulo DEPTH).
- `out_valid` = (count ≠ 0).
- `out_data` = `mem[rd_ptr]`. It is defined only while `out_valid`=1.
- `count` update per cycle:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
- Full (count = DEPTH):
  - Push with a simultaneous pop is accepted.
  - Push with no pop is dropped. `overflow` goes to 1, and the FIFO contents, pointers and count are unchanged.
- Empty: `out_ready` is ignored and nothing changes.
- `upstream_hold` is a registered output equal to (next count ≥ DEPTH − RESERVE).
- `overflow` clears only on `rst`.
- Order is preserved: pops return words in push order.

## Timing
- Reset values of every output:
  - `out_valid`=0, `count`=0, `overflow`=0, `upstream_hold`=0.
  - Pointers are 0.
  - `out_data` is undefined (memory is not cleared).
- A `rst` asserted mid-stream discards all queued words on that edge. An `in_valid` in the same cycle is ignored.
- Latency: `in_valid` in cycle N gives `out_valid`=1 and the word on `out_data` in cycle N+1 (FIFO was empty, no fall-through).
- A pop in cycle N presents the next head in cycle N+1.
- `upstream_hold` follows `count` with the same timing: both reflect the edge that ends the cycle.
- Throughput: one push and one pop per cycle, sustained.
- RESERVE must cover MAC latency + 1 feeder cycle. If that holds, `overflow` never sets in a correctly throttled system.

## Test plan
- Single push, pass-through: in_valid 1 cycle, opcode 0, data 16'h3C00 → next cycle out_valid=1, out_data=16'h3C00, count=1. Pop with out_ready → count=0, out_valid=0.
- Post-op coverage:
  - opcode 1: 16'hBC00 → 16'h0000; 16'h8000 → 16'h0000; 16'hFE01 → 16'hFE01; 16'h4200 → 16'h4200.
  - opcode 2: 16'h4200 → 16'hC200.
  - opcode 3: 16'hFC00 → 16'h7C00.
- Hold threshold (DEPTH=8, RESERVE=4): push 4 words with out_ready=0 → upstream_hold rises the cycle after the 4th push. Pop 1 → upstream_hold falls next cycle.
- Overflow and full boundary (DEPTH=8, RESERVE=4):
  - Push 9 words (16'h0001…16'h0009) with out_ready=0 → count=8, overflow=1. Draining returns 0001…0008 in order; 0009 is lost.
  - Second run: at full, push 16'h00AA with out_ready=1 → count stays 8, no overflow, 16'h00AA comes out last.
- Wrap-around and reset: with out_ready=1 held, stream 20 words (16'h0100+i) → all 20 emerge in order at 1 word/cycle. Then assert rst with 3 words queued → next cycle count=0, out_valid=0, upstream_hold=0, overflow=0.
